// File: rtl/mmc_pkg.sv
// rtl/mmc_pkg.sv - shared state encoding and mode constants for the multi-modulus counter
package mmc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mmc_state_t;

  localparam logic MODE_CONT    = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;

endpackage

// File: rtl/mmc_channel.sv
// rtl/mmc_channel.sv - one modulus counter channel with run-control FSM and shadow modulus
module mmc_channel
  import mmc_pkg::*;
#(
  parameter int BITS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic            mode,
  input  logic            start,
  input  logic            stop,
  input  logic            mn_wr,
  input  logic [BITS-1:0] mn_in,
  output logic [BITS-1:0] count,
  output logic            max_tick,
  output logic            busy,
  output logic            done
);

  mmc_state_t      state, state_next;
  logic [BITS-1:0] count_next;
  logic [BITS-1:0] mn_shadow, mn_shadow_next;
  logic [BITS-1:0] mn_active, mn_active_next;
  logic            done_next;
  logic            term;

  // A write in the same cycle as start or wrap is seen immediately.
  assign mn_shadow_next = mn_wr ? mn_in : mn_shadow;

  // Zero modulus never matches, so a channel armed with 0 stalls in RUN.
  assign term = (state == RUN) && en && (mn_active != '0) &&
                (count == mn_active - BITS'(1));

  assign max_tick = term;
  assign busy     = (state == RUN);

  // Next-state and datapath: stop beats start beats counting.
  always_comb begin
    state_next     = state;
    count_next     = count;
    mn_active_next = mn_active;
    done_next      = done;
    if (stop) begin
      state_next = IDLE;
      count_next = '0;
      done_next  = 1'b0;
    end else if (start) begin
      state_next     = RUN;
      count_next     = '0;
      done_next      = 1'b0;
      mn_active_next = mn_shadow_next;
    end else begin
      case (state)
        RUN: begin
          if (term) begin
            count_next = '0;
            case (mode)
              MODE_CONT: mn_active_next = mn_shadow_next;
              MODE_ONESHOT: begin
                state_next = DONE;
                done_next  = 1'b1;
              end
            endcase
          end else if (en && (mn_active != '0)) begin
            count_next = count + BITS'(1);
          end
        end
        default: count_next = '0;
      endcase
    end
  end

  // State, count and modulus registers; reset clears everything at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      mn_shadow <= '0;
      mn_active <= '0;
      done      <= 1'b0;
    end else begin
      state     <= state_next;
      count     <= count_next;
      mn_shadow <= mn_shadow_next;
      mn_active <= mn_active_next;
      done      <= done_next;
    end
  end

endmodule

// File: rtl/multi_modulus_counter.sv
// rtl/multi_modulus_counter.sv - array of independent modulus counter channels
module multi_modulus_counter
  import mmc_pkg::*;
#(
  parameter int BITS     = 32,
  parameter int CHANNELS = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [CHANNELS-1:0]      en,
  input  logic [CHANNELS-1:0]      mode,
  input  logic [CHANNELS-1:0]      start,
  input  logic [CHANNELS-1:0]      stop,
  input  logic [CHANNELS-1:0]      mn_wr,
  input  logic [BITS-1:0]          mn_in,
  output logic [CHANNELS*BITS-1:0] count,
  output logic [CHANNELS-1:0]      max_tick,
  output logic [CHANNELS-1:0]      busy,
  output logic [CHANNELS-1:0]      done
);

  // One channel per lane; mn_in is shared and qualified by each lane's mn_wr.
  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    mmc_channel #(
      .BITS(BITS)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .en      (en[g]),
      .mode    (mode[g]),
      .start   (start[g]),
      .stop    (stop[g]),
      .mn_wr   (mn_wr[g]),
      .mn_in   (mn_in),
      .count   (count[g*BITS +: BITS]),
      .max_tick(max_tick[g]),
      .busy    (busy[g]),
      .done    (done[g])
    );
  end

endmodule

// File: tb/tb_multi_modulus_counter.sv
// tb/tb_multi_modulus_counter.sv - directed table-driven bench for multi_modulus_counter
module tb_multi_modulus_counter;

  localparam int BITS = 8;
  localparam int CH   = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [CH-1:0]     en, mode, start, stop, mn_wr;
  logic [BITS-1:0]   mn_in;
  logic [CH*BITS-1:0] count;
  logic [CH-1:0]     max_tick, busy, done;

  int checks   = 0;
  int failures = 0;

  multi_modulus_counter #(.BITS(BITS), .CHANNELS(CH)) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .mode    (mode),
    .start   (start),
    .stop    (stop),
    .mn_wr   (mn_wr),
    .mn_in   (mn_in),
    .count   (count),
    .max_tick(max_tick),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic           en, mode, start, stop, wr;
    logic [BITS-1:0] mn;
    logic [BITS-1:0] exp_count;
    logic           exp_tick, exp_busy, exp_done;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic e, input logic m, input logic s, input logic p,
                              input logic w, input int mn, input int c, input logic t,
                              input logic b, input logic d);
    vec_t v;
    v.en = e; v.mode = m; v.start = s; v.stop = p; v.wr = w;
    v.mn = BITS'(mn); v.exp_count = BITS'(c);
    v.exp_tick = t; v.exp_busy = b; v.exp_done = d;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    en = '0; mode = '0; start = '0; stop = '0; mn_wr = '0; mn_in = '0;
  endtask

  function automatic logic [BITS-1:0] ch_count(input int i);
    return count[i*BITS +: BITS];
  endfunction

  initial begin
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("reset count", 32'(count), 32'd0);
    check("reset tick", 32'(max_tick), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    reset = 1'b0;

    // Channel 0 per-cycle vectors: inputs applied, outputs checked before the edge.
    vecs.push_back(mk(0,0,0,0,1,5, 0,0,0,0));
    vecs.push_back(mk(1,0,1,0,0,0, 0,0,0,0));
    vecs.push_back(mk(1,0,0,0,0,0, 0,0,1,0));
    vecs.push_back(mk(1,0,0,0,0,0, 1,0,1,0));
    vecs.push_back(mk(1,0,0,0,0,0, 2,0,1,0));
    vecs.push_back(mk(1,0,0,0,0,0, 3,0,1,0));
    vecs.push_back(mk(1,0,0,0,0,0, 4,1,1,0));
    vecs.push_back(mk(1,0,0,0,0,0, 0,0,1,0));
    vecs.push_back(mk(1,0,0,0,1,3, 1,0,1,0));
    vecs.push_back(mk(1,0,0,0,0,0, 2,0,1,0));
    vecs.push_back(mk(1,0,0,0,0,0, 3,0,1,0));
    vecs.push_back(mk(1,0,0,0,0,0, 4,1,1,0));
    for (int k = 0; k < 6; k++)
      vecs.push_back(mk(1,0,0,0,0,0, k % 3, (k % 3) == 2, 1, 0));
    vecs.push_back(mk(1,0,0,1,0,0, 0,0,1,0));
    vecs.push_back(mk(1,0,0,0,0,0, 0,0,0,0));
    // one-shot, modulus 4, en dropped for two cycles at count 2
    vecs.push_back(mk(1,1,1,0,1,4, 0,0,0,0));
    vecs.push_back(mk(1,1,0,0,0,0, 0,0,1,0));
    vecs.push_back(mk(1,1,0,0,0,0, 1,0,1,0));
    vecs.push_back(mk(0,1,0,0,0,0, 2,0,1,0));
    vecs.push_back(mk(0,1,0,0,0,0, 2,0,1,0));
    vecs.push_back(mk(1,1,0,0,0,0, 2,0,1,0));
    vecs.push_back(mk(1,1,0,0,0,0, 3,1,1,0));
    vecs.push_back(mk(1,1,0,0,0,0, 0,0,0,1));
    vecs.push_back(mk(1,1,0,0,0,0, 0,0,0,1));
    vecs.push_back(mk(1,1,1,0,0,0, 0,0,0,1));
    vecs.push_back(mk(1,1,0,0,0,0, 0,0,1,0));
    vecs.push_back(mk(1,1,0,1,0,0, 1,0,1,0));
    vecs.push_back(mk(1,0,0,0,0,0, 0,0,0,0));
    // modulus 1: tick on every enabled RUN cycle
    vecs.push_back(mk(1,0,1,0,1,1, 0,0,0,0));
    vecs.push_back(mk(1,0,0,0,0,0, 0,1,1,0));
    vecs.push_back(mk(1,0,0,0,0,0, 0,1,1,0));
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,1,0));
    vecs.push_back(mk(1,0,0,0,0,0, 0,1,1,0));
    // restart with modulus 0: stalled in RUN
    vecs.push_back(mk(1,0,1,0,1,0, 0,1,1,0));
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(1,0,0,0,0,0, 0,0,1,0));
    // start and stop together -> IDLE
    vecs.push_back(mk(1,0,1,1,0,0, 0,0,1,0));
    vecs.push_back(mk(1,0,0,0,0,0, 0,0,0,0));
    // start with simultaneous modulus write of 7
    vecs.push_back(mk(1,0,1,0,1,7, 0,0,0,0));
    for (int k = 0; k < 7; k++)
      vecs.push_back(mk(1,0,0,0,0,0, k, k == 6, 1, 0));
    vecs.push_back(mk(1,0,0,0,0,0, 0,0,1,0));
    vecs.push_back(mk(1,0,0,1,0,0, 1,0,1,0));
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,0,0));

    foreach (vecs[i]) begin
      @(negedge clk);
      idle_inputs();
      en[0] = vecs[i].en; mode[0] = vecs[i].mode; start[0] = vecs[i].start;
      stop[0] = vecs[i].stop; mn_wr[0] = vecs[i].wr; mn_in = vecs[i].mn;
      #1;
      check($sformatf("v%0d count", i), 32'(ch_count(0)), 32'(vecs[i].exp_count));
      check($sformatf("v%0d tick", i), 32'(max_tick[0]), 32'(vecs[i].exp_tick));
      check($sformatf("v%0d busy", i), 32'(busy[0]), 32'(vecs[i].exp_busy));
      check($sformatf("v%0d done", i), 32'(done[0]), 32'(vecs[i].exp_done));
    end

    // Two channels, moduli 3 and 4, ticks coincide on the 12th RUN cycle.
    @(negedge clk); idle_inputs(); mn_wr[1] = 1'b1; mn_in = 8'd3;
    @(negedge clk); idle_inputs(); mn_wr[2] = 1'b1; mn_in = 8'd4;
    @(negedge clk); idle_inputs(); start[2:1] = 2'b11; en[2:1] = 2'b11;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      idle_inputs(); en[2:1] = 2'b11;
      #1;
      check($sformatf("dual k%0d tick1", k), 32'(max_tick[1]), 32'((k % 3) == 0));
      check($sformatf("dual k%0d tick2", k), 32'(max_tick[2]), 32'((k % 4) == 0));
      check($sformatf("dual k%0d count2", k), 32'(ch_count(2)), 32'((k - 1) % 4));
      check($sformatf("dual k%0d ch0 idle", k), 32'(busy[0]), 32'd0);
    end

    // Full-range modulus on channel 0: wraps from 2^BITS-2 to 0.
    @(negedge clk); idle_inputs(); stop[2:1] = 2'b11;
    @(negedge clk); idle_inputs(); start[0] = 1'b1; mn_wr[0] = 1'b1; mn_in = 8'hFF; en[0] = 1'b1;
    for (int k = 0; k <= 255; k++) begin
      @(negedge clk);
      idle_inputs(); en[0] = 1'b1;
      #1;
      if (k >= 253) begin
        check($sformatf("wide k%0d count", k), 32'(ch_count(0)), 32'(k % 255));
        check($sformatf("wide k%0d tick", k), 32'(max_tick[0]), 32'(k == 254));
      end
    end

    // Asynchronous reset mid-count on channel 3.
    @(negedge clk); idle_inputs(); start[3] = 1'b1; mn_wr[3] = 1'b1; mn_in = 8'd5; en[3] = 1'b1;
    repeat (3) begin
      @(negedge clk); idle_inputs(); en[3] = 1'b1;
    end
    #1;
    check("pre-reset count3", 32'(ch_count(3)), 32'd2);
    #1 reset = 1'b1;
    #1;
    check("async reset count", 32'(count), 32'd0);
    check("async reset busy", 32'(busy), 32'd0);
    check("async reset tick", 32'(max_tick), 32'd0);
    @(negedge clk); reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      check($sformatf("post-reset k%0d busy3", k), 32'(busy[3]), 32'd0);
      check($sformatf("post-reset k%0d count3", k), 32'(ch_count(3)), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
